encoder: RTL and testbench
==========================

ENCODER -- requirements
Module: encoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, address width of all three internal memories (depth N = 2**ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH, default 8, word width of all memories; DATA_WIDTH SHALL be at least ADDR_WIDTH+1 so a run length of N fits.
REQ-003 The module SHALL have one clock and an asynchronous active-high reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous reset, asserted high.
REQ-004 cs input 1: chip select; a low-to-high or held-high level while in IDLE starts one encode pass.
REQ-005 ld_we input 1: input-memory write strobe, honoured only in IDLE.
REQ-006 ld_addr input ADDR_WIDTH: input-memory write address.
REQ-007 ld_data input DATA_WIDTH: input-memory write data.
REQ-008 rd_addr input ADDR_WIDTH: read address for both result memories (combinational read).
REQ-009 rd_char output DATA_WIDTH: output_ram[rd_addr].
REQ-010 rd_code output DATA_WIDTH: output_code_ram[rd_addr].
REQ-011 runs output ADDR_WIDTH+1: number of (char, length) pairs produced by the last pass.
REQ-012 done output 1: high from pass completion until cs goes low.

Function
REQ-013 The design SHALL be a run-length encoder with instances input_ram, output_ram, output_code_ram (each N x DATA_WIDTH, array named mem) and a sub-block instance grouper.
REQ-014 Encoder FSM (register state) SHALL have states IDLE, RUN, DONE; IDLE->RUN when cs=1; RUN->DONE when grouper signals end; DONE->IDLE when cs=0.
REQ-015 Grouper FSM (register grouper.state) SHALL have states G_IDLE, G_LOAD, G_CMP, G_EMIT, G_END.
REQ-016 av SHALL be the input read address, starting at 0 and incrementing by one per consumed byte; one byte SHALL be consumed per cycle in G_CMP.
REQ-017 ao_current_char SHALL hold the character of the current run; ac SHALL hold its length (starting at 1 on G_LOAD).
REQ-018 When the next byte equals ao_current_char, ac SHALL increment; otherwise G_EMIT SHALL write ao_current_char to output_ram.mem[ao] and ac to output_code_ram.mem[ao] (a_output_code = ac), increment ao, and reload the run with the new byte.
REQ-019 e SHALL assert when av reaches N-1 consumed; the final run SHALL then be emitted and grouper SHALL enter G_END; npo/npv SHALL be the next output address and its valid flag.
REQ-020 runs SHALL equal ao after the final emit; done SHALL rise in the cycle state enters DONE.
REQ-021 A pass over N bytes SHALL complete in at most 2N+4 clock cycles after cs rises.
REQ-022 Input memory writes outside IDLE SHALL be ignored; result memories SHALL keep contents until the next pass overwrites them.
REQ-023 cs dropping during RUN SHALL NOT abort the pass.

Reset
REQ-024 rst_n high SHALL immediately force state=IDLE, grouper.state=G_IDLE, av=ao=ac=0, ao_current_char=0, e=npv=0, runs=0, done=0.
REQ-025 Reset SHALL NOT clear memory contents; reset mid-pass SHALL abandon the pass and a new cs start SHALL restart from address 0.

Configuration
REQ-026 Macro ENCODER_ZERO_TERM_EN: when defined, a byte value 0 SHALL terminate input (not encoded, final run emitted, pass ends); when undefined, all N bytes SHALL be encoded and 0 is an ordinary character.

Verification
REQ-027 Load all 16 bytes 0x41, pulse cs -> runs=1, output_ram[0]=0x41, output_code_ram[0]=16, done=1.
REQ-028 Load 0..15 distinct values -> runs=16, output_code_ram[k]=1 and output_ram[k]=k for all k.
REQ-029 Load AAAABBBCCDEEEEEE (hex 41/42/43/44/45) -> runs=5, codes 4,3,2,1,6 in order.
REQ-030 Assert rst_n mid-RUN at cycle 5, release, restart -> state IDLE immediately, second pass results match a clean pass.
REQ-031 With ENCODER_ZERO_TERM_EN, load 41 41 42 00 ... -> runs=2, codes 2,1; without it the 0x00 bytes form a run.
REQ-032 ld_we during RUN with a different value -> results unchanged, input_ram.mem unchanged.

Source files
------------

// File: rtl/encoder.sv
// Run-length encoder: reads N input bytes and writes (char, run length) pairs
// into two result memories that share one combinational read port.
// Optional build macro: ENCODER_ZERO_TERM_EN -- a 0x00 byte ends the input.

// Simple N x DATA_WIDTH memory: synchronous write, combinational read, never reset
module enc_ram #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int unsigned N = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [N];

   // Write port; contents survive reset by design
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// Walks the input memory once and emits one (char, length) record per run
module grouper #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] av,
   output logic [ADDR_WIDTH:0]   ao,
   output logic [ADDR_WIDTH:0]   ac,
   output logic [DATA_WIDTH-1:0] ao_current_char,
   output logic [ADDR_WIDTH-1:0] npo,
   output logic                  we_c,
   output logic                  end_c
);
   localparam int unsigned AC_W = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {G_IDLE, G_LOAD, G_CMP, G_EMIT, G_END} g_state_t;

   g_state_t state;
   logic     e;
   logic     npv;
   logic     last_c;
   logic     term_c;

   // The byte at av is the last one of the memory
   assign last_c = &av;

`ifdef ENCODER_ZERO_TERM_EN
   assign term_c = (rdata == '0);
`else
   assign term_c = 1'b0;
`endif

   assign we_c  = (state == G_EMIT) && npv;
   assign end_c = (state == G_END);

   // Run grouping FSM: one byte consumed per cycle, a run is emitted on a change
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state           <= G_IDLE;
         av              <= '0;
         ao              <= '0;
         ac              <= '0;
         ao_current_char <= '0;
         npo             <= '0;
         e               <= 1'b0;
         npv             <= 1'b0;
      end else begin
         case (state)
            G_IDLE: begin
               if (start) begin
                  av    <= '0;
                  ao    <= '0;
                  ac    <= '0;
                  npo   <= '0;
                  e     <= 1'b0;
                  npv   <= 1'b1;
                  state <= G_LOAD;
               end
            end
            G_LOAD: begin
               if (term_c) begin
                  e     <= 1'b1;
                  state <= G_END;
               end else begin
                  ao_current_char <= rdata;
                  ac              <= AC_W'(1);
                  if (last_c) begin
                     e     <= 1'b1;
                     state <= G_EMIT;
                  end else begin
                     av    <= av + 1'b1;
                     state <= G_CMP;
                  end
               end
            end
            G_CMP: begin
               if (term_c) begin
                  e     <= 1'b1;
                  state <= G_EMIT;
               end else if (rdata == ao_current_char) begin
                  ac <= ac + 1'b1;
                  if (last_c) begin
                     e     <= 1'b1;
                     state <= G_EMIT;
                  end else begin
                     av <= av + 1'b1;
                  end
               end else begin
                  // mismatch: byte at av is not consumed, it opens the next run
                  state <= G_EMIT;
               end
            end
            G_EMIT: begin
               ao  <= ao + 1'b1;
               npo <= npo + 1'b1;
               if (e) begin
                  state <= G_END;
               end else if (term_c) begin
                  e     <= 1'b1;
                  state <= G_END;
               end else begin
                  ao_current_char <= rdata;
                  ac              <= AC_W'(1);
                  if (last_c) begin
                     e     <= 1'b1;
                     state <= G_EMIT;
                  end else begin
                     av    <= av + 1'b1;
                     state <= G_CMP;
                  end
               end
            end
            G_END: begin
               npv   <= 1'b0;
               state <= G_IDLE;
            end
            default: state <= G_IDLE;
         endcase
      end
   end
endmodule

module encoder #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  ld_we,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_char,
   output logic [DATA_WIDTH-1:0] rd_code,
   output logic [ADDR_WIDTH:0]   runs,
   output logic                  done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state;
   logic                  start_c;
   logic                  in_we_c;
   logic [DATA_WIDTH-1:0] in_rdata;
   logic [ADDR_WIDTH-1:0] g_av;
   logic [ADDR_WIDTH:0]   g_ao;
   logic [ADDR_WIDTH:0]   g_ac;
   logic [DATA_WIDTH-1:0] g_char;
   logic [ADDR_WIDTH-1:0] g_npo;
   logic                  g_we_c;
   logic                  g_end_c;
   logic [DATA_WIDTH-1:0] a_output_code;

   assign start_c       = (state == IDLE) && cs;
   assign in_we_c       = (state == IDLE) && ld_we;
   assign a_output_code = DATA_WIDTH'(g_ac);

   // Top-level pass control and result registers
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state <= IDLE;
         runs  <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cs) state <= RUN;
            end
            RUN: begin
               if (g_end_c) begin
                  state <= DONE;
                  done  <= 1'b1;
                  runs  <= g_ao;
               end
            end
            DONE: begin
               if (!cs) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   enc_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) input_ram (
      .clk   (clk),
      .we    (in_we_c),
      .waddr (ld_addr),
      .wdata (ld_data),
      .raddr (g_av),
      .rdata (in_rdata)
   );

   enc_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) output_ram (
      .clk   (clk),
      .we    (g_we_c),
      .waddr (g_npo),
      .wdata (g_char),
      .raddr (rd_addr),
      .rdata (rd_char)
   );

   enc_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) output_code_ram (
      .clk   (clk),
      .we    (g_we_c),
      .waddr (g_npo),
      .wdata (a_output_code),
      .raddr (rd_addr),
      .rdata (rd_code)
   );

   grouper #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) grouper (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start_c),
      .rdata           (in_rdata),
      .av              (g_av),
      .ao              (g_ao),
      .ac              (g_ac),
      .ao_current_char (g_char),
      .npo             (g_npo),
      .we_c            (g_we_c),
      .end_c           (g_end_c)
   );
endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the run-length encoder: directed patterns plus
// random images compared against a loop-based run-length reference.
module tb_encoder;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned N  = 16;

   logic          clk;
   logic          rst_n;
   logic          cs;
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_char;
   logic [DW-1:0] rd_code;
   logic [AW:0]   runs;
   logic          done;

   int n_cmp  = 0;
   int n_fail = 0;
   int pass_cyc;

   logic [DW-1:0] img    [N];
   int            exp_runs;
   logic [DW-1:0] exp_ch [N];
   int            exp_cd [N];

   encoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cs      (cs),
      .ld_we   (ld_we),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .rd_addr (rd_addr),
      .rd_char (rd_char),
      .rd_code (rd_code),
      .runs    (runs),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: scan the image, group equal neighbours, count their lengths
   function automatic void run_model();
      int i;
      logic [DW-1:0] c;
      int len;
      exp_runs = 0;
      i = 0;
      while (i < int'(N)) begin
`ifdef ENCODER_ZERO_TERM_EN
         if (img[i] == 8'h00) break;
`endif
         c = img[i];
         len = 0;
         while (i < int'(N) && img[i] == c) begin
            i++;
            len++;
         end
         exp_ch[exp_runs] = c;
         exp_cd[exp_runs] = len;
         exp_runs++;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      pass_cyc++;
   endtask

   task automatic load_image();
      for (int i = 0; i < int'(N); i++) begin
         ld_we   = 1'b1;
         ld_addr = AW'(i);
         ld_data = img[i];
         tick();
      end
      ld_we = 1'b0;
   endtask

   task automatic start_pass();
      cs       = 1'b1;
      pass_cyc = 0;
   endtask

   task automatic wait_done(input string tag);
      while (done !== 1'b1 && pass_cyc < 200) tick();
      check({tag, ":done"}, 32'(done), 32'd1);
      check({tag, ":latency_ok"}, 32'(pass_cyc <= int'(2 * N + 4)), 32'd1);
   endtask

   task automatic check_results(input string tag);
      check({tag, ":runs"}, 32'(runs), 32'(exp_runs));
      for (int k = 0; k < exp_runs; k++) begin
         rd_addr = AW'(k);
         #1;
         check($sformatf("%s:char[%0d]", tag, k), 32'(rd_char), 32'(exp_ch[k]));
         check($sformatf("%s:code[%0d]", tag, k), 32'(rd_code), 32'(exp_cd[k]));
      end
   endtask

   task automatic end_pass(input string tag);
      cs = 1'b0;
      tick();
      tick();
      check({tag, ":done_low"}, 32'(done), 32'd0);
   endtask

   task automatic full_pass(input string tag);
      load_image();
      run_model();
      start_pass();
      wait_done(tag);
      check_results(tag);
      end_pass(tag);
   endtask

   initial begin
      rst_n   = 1'b1;
      cs      = 1'b0;
      ld_we   = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      rd_addr = '0;
      pass_cyc = 0;
      tick();
      tick();
      check("rst:runs", 32'(runs), 32'd0);
      check("rst:done", 32'(done), 32'd0);
      check("rst:av", 32'(dut.grouper.av), 32'd0);
      check("rst:ac", 32'(dut.grouper.ac), 32'd0);
      rst_n = 1'b0;
      tick();

      // single long run
      for (int i = 0; i < int'(N); i++) img[i] = 8'h41;
      full_pass("all41");

      // all distinct
      for (int i = 0; i < int'(N); i++) img[i] = DW'(i);
      full_pass("distinct");

      // AAAABBBCCDEEEEEE
      for (int i = 0; i < int'(N); i++)
         img[i] = (i < 4) ? 8'h41 : (i < 7) ? 8'h42 : (i < 9) ? 8'h43 : (i < 10) ? 8'h44 : 8'h45;
      full_pass("mixed");

      // results persist while a new image is loaded
      for (int i = 0; i < int'(N); i++) img[i] = (i < 2) ? 8'h41 : (i == 2) ? 8'h42 : 8'h00;
      load_image();
      rd_addr = '0;
      #1;
      check("persist:char0", 32'(rd_char), 32'h41);
      check("persist:code0", 32'(rd_code), 32'd4);
      full_pass("zeros");

      // input writes during RUN are ignored
      for (int i = 0; i < int'(N); i++) img[i] = 8'h41 + DW'(i / 3);
      load_image();
      run_model();
      start_pass();
      tick();
      tick();
      ld_we   = 1'b1;
      ld_addr = AW'(3);
      ld_data = ~img[3];
      tick();
      ld_we   = 1'b0;
      wait_done("ldrun");
      check_results("ldrun");
      check("ldrun:mem3", 32'(dut.input_ram.mem[3]), 32'(img[3]));
      end_pass("ldrun");

      // cs dropped mid-pass still completes
      for (int i = 0; i < int'(N); i++) img[i] = 8'h50 + DW'(i % 2);
      load_image();
      run_model();
      start_pass();
      tick();
      tick();
      cs = 1'b0;
      wait_done("csdrop");
      check_results("csdrop");
      end_pass("csdrop");

      // reset at cycle 5 of a pass, then a clean restart
      for (int i = 0; i < int'(N); i++) img[i] = 8'h60 + DW'(i / 5);
      load_image();
      run_model();
      start_pass();
      repeat (5) tick();
      rst_n = 1'b1;
      #1;
      check("midrst:done", 32'(done), 32'd0);
      check("midrst:runs", 32'(runs), 32'd0);
      check("midrst:av", 32'(dut.grouper.av), 32'd0);
      check("midrst:ao", 32'(dut.grouper.ao), 32'd0);
      cs = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      start_pass();
      wait_done("restart");
      check_results("restart");
      end_pass("restart");

      // random images against the reference
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < int'(N); i++) begin
            if ($urandom_range(0, 9) == 0) img[i] = 8'h00;
            else img[i] = 8'h41 + DW'($urandom_range(0, 2));
         end
         full_pass($sformatf("rand%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
